// File: rtl/inst_buffer.sv
// inst_buffer: FIFO between fetch and decode holding {pc, pc+4, inst}; define INST_BUFFER_BYPASS_EN to forward pushes straight to pop_* when empty
module inst_buffer #(
   parameter int ADDR_WIDTH = 64,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_valid,
   input  logic [ADDR_WIDTH-1:0]        push_pc,
   input  logic [ADDR_WIDTH-1:0]        push_pc4,
   input  logic [INST_WIDTH-1:0]        push_inst,
   output logic                         push_ready,
   input  logic                         flush,
   input  logic                         pop_ready,
   output logic                         pop_valid,
   output logic [ADDR_WIDTH-1:0]        pop_pc,
   output logic [ADDR_WIDTH-1:0]        pop_pc4,
   output logic [INST_WIDTH-1:0]        pop_inst,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full,
   output logic                         overflow_err
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
   logic [ADDR_WIDTH-1:0] mem_pc4  [DEPTH];
   logic [INST_WIDTH-1:0] mem_inst [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic                  bypass, do_push, do_pop;

   assign empty      = count == '0;
   assign full       = count == CW'(DEPTH);
   assign push_ready = !full;

`ifdef INST_BUFFER_BYPASS_EN
   assign bypass    = empty && push_valid && pop_ready && !flush;
   assign pop_valid = !empty || bypass;
   assign pop_pc    = bypass ? push_pc   : mem_pc[rd_ptr];
   assign pop_pc4   = bypass ? push_pc4  : mem_pc4[rd_ptr];
   assign pop_inst  = bypass ? push_inst : mem_inst[rd_ptr];
`else
   assign bypass    = 1'b0;
   assign pop_valid = !empty;
   assign pop_pc    = mem_pc[rd_ptr];
   assign pop_pc4   = mem_pc4[rd_ptr];
   assign pop_inst  = mem_inst[rd_ptr];
`endif

   // a bypassed entry is consumed in flight, so it neither enqueues nor dequeues
   assign do_push = push_valid && push_ready && !flush && !bypass;
   assign do_pop  = !empty && pop_ready && !flush;

   // storage: cleared on reset so pop_* never carries X, written at wr_ptr on push
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc[i]   <= '0;
            mem_pc4[i]  <= '0;
            mem_inst[i] <= '0;
         end
      end else if (do_push) begin
         mem_pc[wr_ptr]   <= push_pc;
         mem_pc4[wr_ptr]  <= push_pc4;
         mem_inst[wr_ptr] <= push_inst;
      end
   end

   // pointers, occupancy and sticky overflow; reset beats flush beats push/pop
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
         if (push_valid && full) overflow_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: randomized and directed checks of inst_buffer against a queue-based reference model
module tb_inst_buffer;
   localparam int AW = 64, IW = 32, DEPTH = 4;

   typedef struct {
      logic [AW-1:0] pc;
      logic [AW-1:0] pc4;
      logic [IW-1:0] inst;
   } entry_t;

   logic clk = 1'b0, reset = 1'b0;
   logic push_valid = 1'b0, flush = 1'b0, pop_ready = 1'b0;
   logic [AW-1:0] push_pc = '0, push_pc4 = '0;
   logic [IW-1:0] push_inst = '0;
   logic push_ready, pop_valid, empty, full, overflow_err;
   logic [AW-1:0] pop_pc, pop_pc4;
   logic [IW-1:0] pop_inst;
   logic [2:0] count;

   int total = 0, bad = 0;
   entry_t q[$];
   logic m_ovf = 1'b0;
   logic seen_pop_valid;

   inst_buffer #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .push_valid(push_valid), .push_pc(push_pc),
      .push_pc4(push_pc4), .push_inst(push_inst), .push_ready(push_ready),
      .flush(flush), .pop_ready(pop_ready), .pop_valid(pop_valid),
      .pop_pc(pop_pc), .pop_pc4(pop_pc4), .pop_inst(pop_inst), .count(count),
      .empty(empty), .full(full), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock cycle: drive, check outputs against the model before the edge, then advance the model
   task automatic step(input logic pv, input logic [AW-1:0] pc, input logic [IW-1:0] inst,
                       input logic pr, input logic fl, input logic rs);
      int n;
      logic byp, exp_valid;
      entry_t e;
      push_valid = pv; push_pc = pc; push_pc4 = pc + 4; push_inst = inst;
      pop_ready = pr; flush = fl; reset = rs;
      #1;
      n = q.size();
`ifdef INST_BUFFER_BYPASS_EN
      byp = (n == 0) && pv && pr && !fl;
`else
      byp = 1'b0;
`endif
      exp_valid = (n > 0) || byp;
      seen_pop_valid = pop_valid;
      check("count", AW'(count), AW'(n));
      check("empty", AW'(empty), AW'(n == 0));
      check("full", AW'(full), AW'(n == DEPTH));
      check("push_ready", AW'(push_ready), AW'(n < DEPTH));
      check("pop_valid", AW'(pop_valid), AW'(exp_valid));
      check("overflow_err", AW'(overflow_err), AW'(m_ovf));
      check("no_x", AW'($isunknown({pop_pc, pop_pc4, pop_inst})), '0);
      if (exp_valid) begin
         e = byp ? entry_t'{pc, pc + 4, inst} : q[0];
         check("pop_pc", pop_pc, e.pc);
         check("pop_pc4", pop_pc4, e.pc4);
         check("pop_inst", AW'(pop_inst), AW'(e.inst));
      end
      @(posedge clk);
      if (!rs || fl) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         if (pv && n == DEPTH) m_ovf = 1'b1;
         if (n > 0 && pr) void'(q.pop_front());
         if (pv && n < DEPTH && !byp) q.push_back(entry_t'{pc, pc + 4, inst});
      end
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      // reset state
      step(0, 0, 0, 0, 0, 1);
      // fill with 0x0..0xC, then drain in order
      for (int i = 0; i < 4; i++) step(1, AW'(4 * i), IW'(32'h100 + i), 0, 0, 1);
      check("fill_full", AW'(full), 1);
      check("fill_count", AW'(count), 4);
      check("fill_push_ready", AW'(push_ready), 0);
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", pop_pc, AW'(4 * i));
         step(0, 0, 0, 1, 0, 1);
      end
      check("drain_empty", AW'(empty), 1);
      // full with push and pop together: one pop, push refused, overflow set
      for (int i = 0; i < 4; i++) step(1, AW'(16 + 4 * i), IW'(i), 0, 0, 1);
      step(1, 64'h99, 32'h99, 1, 0, 1);
      check("ovf_count", AW'(count), 3);
      check("ovf_set", AW'(overflow_err), 1);
      // flush beats push and pop, clears overflow
      step(0, 0, 0, 1, 0, 1);
      check("pre_flush_count", AW'(count), 2);
      step(1, 64'h55, 32'h55, 1, 1, 1);
      check("flush_count", AW'(count), 0);
      check("flush_valid", AW'(pop_valid), 0);
      check("flush_ovf", AW'(overflow_err), 0);
      // steady state count=1 over 10 cycles wraps pointers
      step(1, 64'h1000, 32'hA000_0000, 0, 0, 1);
      for (int i = 1; i <= 10; i++) step(1, AW'(64'h1000 + 4 * i), IW'(32'hA000_0000 + i), 1, 0, 1);
      check("steady_count", AW'(count), 1);
      check("steady_last", AW'(pop_inst), AW'(32'hA000_000A));
      step(0, 0, 0, 1, 0, 1);
      // push into empty with pop_ready set
      step(1, 64'h2000, 32'h0000_0013, 1, 0, 1);
`ifdef INST_BUFFER_BYPASS_EN
      check("byp_same_cycle", AW'(seen_pop_valid), 1);
      check("byp_count", AW'(count), 0);
`else
      check("nobyp_same_cycle", AW'(seen_pop_valid), 0);
      check("nobyp_next_valid", AW'(pop_valid), 1);
      check("nobyp_next_inst", AW'(pop_inst), AW'(32'h13));
      step(0, 0, 0, 1, 0, 1);
`endif
      // reset with 3 entries and a push pending
      for (int i = 0; i < 3; i++) step(1, AW'(64'h3000 + 4 * i), IW'(i), 0, 0, 1);
      step(1, 64'h4000, 32'h4, 1, 1, 0);
      check("rst_count", AW'(count), 0);
      check("rst_empty", AW'(empty), 1);
      check("rst_full", AW'(full), 0);
      check("rst_push_ready", AW'(push_ready), 1);
      check("rst_ovf", AW'(overflow_err), 0);
      step(0, 0, 0, 0, 0, 1);
      // random traffic
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 31) == 0, $urandom_range(0, 63) != 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, width of the PC fields.
REQ-002 Parameter INST_WIDTH, default 32, width of the instruction word.
REQ-003 Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-004 The interface SHALL have exactly one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-low reset; 0 = reset, sampled on the clk rising edge.
REQ-007 push_valid  input  1  fetch stage presents an entry.
REQ-008 push_pc  input  ADDR_WIDTH  PC of the fetched instruction.
REQ-009 push_pc4  input  ADDR_WIDTH  PC+4 of the fetched instruction.
REQ-010 push_inst  input  INST_WIDTH  fetched instruction word.
REQ-011 push_ready  output  1  buffer can accept; equals !full, with no combinational dependence on pop_ready.
REQ-012 flush  input  1  discard all entries (branch/jump redirect).
REQ-013 pop_ready  input  1  decode stage consumes the head entry.
REQ-014 pop_valid  output  1  head entry valid.
REQ-015 pop_pc, pop_pc4, pop_inst  output  ADDR_WIDTH/ADDR_WIDTH/INST_WIDTH  head entry fields.
REQ-016 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-017 empty, full  output  1  count==0, count==DEPTH.
REQ-018 overflow_err  output  1  sticky: push attempted while full.

Function
REQ-019 Push SHALL occur on a clock edge when push_valid && push_ready && !flush; the entry is written at the write pointer.
REQ-020 Pop SHALL occur on a clock edge when pop_valid && pop_ready && !flush; the read pointer advances.
REQ-021 Entries SHALL leave in strict FIFO order; pop_* SHALL reflect the head entry whenever pop_valid=1.
REQ-022 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH with no skipped or duplicated slot.
REQ-023 Simultaneous push and pop SHALL leave count unchanged. When full, push_ready=0, so that cycle's push is not accepted even if a pop occurs; the freed slot is visible on the next cycle.
REQ-024 When empty with bypass disabled, pop_valid SHALL be 0. A pushed entry SHALL appear at pop_* one cycle after the push edge.
REQ-025 flush SHALL take priority over push and pop: on the edge, pointers and count are cleared to 0 and any same-cycle push is dropped. overflow_err is cleared.
REQ-026 push_valid=1 while full (and flush=0) SHALL set overflow_err on that edge. Buffer contents are unchanged.
REQ-027 pop_pc, pop_pc4 and pop_inst SHALL be don't-care while pop_valid=0, but SHALL never contain X after reset.

Reset
REQ-028 On reset=0 at a clock edge: pointers=0, count=0, empty=1, full=0, push_ready=1, pop_valid=0, overflow_err=0, and the storage array is cleared to 0.
REQ-029 Reset asserted mid-operation SHALL discard all entries and override flush, push and pop in the same cycle.

Configuration
REQ-030 Macro INST_BUFFER_BYPASS_EN defined: when empty, push_valid=1, pop_ready=1 and flush=0, push data SHALL be forwarded combinationally to pop_* with pop_valid=1. The entry is consumed in that cycle and not stored, so count stays 0.
REQ-031 Macro INST_BUFFER_BYPASS_EN undefined: there is no combinational path from push_* to pop_*, and minimum latency is 1 cycle.

Verification
REQ-032 Reset, then push PCs 0x0,0x4,0x8,0xC with pop_ready=0 -> full=1, count=4, push_ready=0; then pop 4 entries -> pop_pc 0x0,0x4,0x8,0xC in order, then empty=1.
REQ-033 Full buffer, push_valid=1 with pop_ready=1 for one cycle -> one pop, push not accepted, count=3, overflow_err=1.
REQ-034 Buffer holding 2 entries, flush=1 with push_valid=1 and pop_ready=1 -> next cycle count=0, pop_valid=0, overflow_err=0.
REQ-035 Run 10 push/pop cycles at count=1 steady state with DEPTH=4 -> pointers wrap twice and pop_inst sequence equals push_inst sequence.
REQ-036 Empty buffer, push inst 0x00000013 with pop_ready=1 -> with INST_BUFFER_BYPASS_EN, pop_valid=1 the same cycle and count stays 0; without it, pop_valid=1 the next cycle.
REQ-037 Assert reset=0 with 3 entries stored and push_valid=1 -> next cycle count=0, empty=1, and outputs match REQ-028.
